// File: rtl/booth_pp_accumulator.sv
// booth_pp_accumulator
// Sequential accumulator for the four radix-4 Booth partial products of an
// 8-bit signed multiply. Each 9-bit partial product arrives LSB digit first
// over a valid/ready handshake. It is sign-extended, shifted by 2*digit and
// added into a 16-bit accumulator. The finished product is then held on an
// output valid/ready handshake until it is taken.
//
// Optional feature: define BOOTH_ACC_CNT_EN to add the prod_count port, a
// wrapping count of completed output handshakes.
module booth_pp_accumulator (
   input  logic               clk,
   input  logic               rst,
   input  logic               pp_valid,
   output logic               pp_ready,
   input  logic signed [8:0]  pp_data,
   output logic [1:0]         pp_idx,
   input  logic               pp_clear,
   output logic               prod_valid,
   input  logic               prod_ready,
   output logic signed [15:0] prod_data
`ifdef BOOTH_ACC_CNT_EN
   ,
   output logic [15:0]        prod_count
`endif
);

   typedef enum logic {
      ACCUM = 1'b0,
      DONE  = 1'b1
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic [1:0]         count;
   logic [1:0]         count_nxt;
   logic signed [15:0] acc;
   logic signed [15:0] acc_nxt;
   logic signed [15:0] prod_reg;
   logic signed [15:0] prod_nxt;
   logic signed [15:0] sum;
   logic               pp_fire;
   logic               prod_fire;

   // Sign-extend a partial product to 16 bits and weight it by its digit
   // position (shift left by 2*idx). Bits above bit 15 wrap away, matching the
   // modulo-2^16 accumulation.
   function automatic logic signed [15:0] pp_term(input logic signed [8:0] pp,
                                                  input logic [1:0]        idx);
      logic signed [15:0] ext;
      logic [2:0]         shamt;
      ext   = {{7{pp[8]}}, pp};
      shamt = {idx, 1'b0};
      return ext <<< shamt;
   endfunction

   // Outputs come straight from registers, so there is no combinational path
   // from pp_valid or prod_ready to any output.
   assign pp_ready   = (state == ACCUM);
   assign prod_valid = (state == DONE);
   assign pp_idx     = count;
   assign prod_data  = prod_reg;

   // pp_clear wins over both handshakes, so neither counts as a transfer.
   assign pp_fire   = (state == ACCUM) && pp_valid   && !pp_clear;
   assign prod_fire = (state == DONE)  && prod_ready && !pp_clear;

   assign sum = acc + pp_term(pp_data, count);

   // Next-state logic: accumulate in ACCUM, hold the product in DONE, abort on pp_clear.
   always_comb begin
      state_nxt = state;
      count_nxt = count;
      acc_nxt   = acc;
      prod_nxt  = prod_reg;
      if (pp_clear) begin
         state_nxt = ACCUM;
         count_nxt = 2'd0;
         acc_nxt   = '0;
      end else begin
         case (state)
            ACCUM: begin
               if (pp_fire) begin
                  if (count == 2'd3) begin
                     prod_nxt  = sum;
                     acc_nxt   = '0;
                     count_nxt = 2'd0;
                     state_nxt = DONE;
                  end else begin
                     acc_nxt   = sum;
                     count_nxt = count + 2'd1;
                  end
               end
            end
            DONE: begin
               if (prod_fire) begin
                  state_nxt = ACCUM;
                  acc_nxt   = '0;
               end
            end
            default: begin
               state_nxt = ACCUM;
               count_nxt = 2'd0;
               acc_nxt   = '0;
            end
         endcase
      end
   end

   // State, accumulator and product registers; rst overrides everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ACCUM;
         count    <= 2'd0;
         acc      <= '0;
         prod_reg <= '0;
      end else begin
         state    <= state_nxt;
         count    <= count_nxt;
         acc      <= acc_nxt;
         prod_reg <= prod_nxt;
      end
   end

`ifdef BOOTH_ACC_CNT_EN
   logic [15:0] cnt;

   // Completed-product counter; only rst clears it, and it wraps naturally at 16 bits.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (prod_fire) begin
         cnt <= cnt + 16'd1;
      end
   end

   assign prod_count = cnt;
`endif

endmodule

// File: tb/tb_booth_pp_accumulator.sv
// Directed self-checking bench for booth_pp_accumulator.
module tb_booth_pp_accumulator;

   logic               clk = 1'b0;
   logic               rst;
   logic               pp_valid;
   logic               pp_ready;
   logic signed [8:0]  pp_data;
   logic [1:0]         pp_idx;
   logic               pp_clear;
   logic               prod_valid;
   logic               prod_ready;
   logic signed [15:0] prod_data;
`ifdef BOOTH_ACC_CNT_EN
   logic [15:0]        prod_count;
`endif

   int n_pass   = 0;
   int n_checks = 0;

   booth_pp_accumulator dut (
      .clk        (clk),
      .rst        (rst),
      .pp_valid   (pp_valid),
      .pp_ready   (pp_ready),
      .pp_data    (pp_data),
      .pp_idx     (pp_idx),
      .pp_clear   (pp_clear),
      .prod_valid (prod_valid),
      .prod_ready (prod_ready),
      .prod_data  (prod_data)
`ifdef BOOTH_ACC_CNT_EN
      ,
      .prod_count (prod_count)
`endif
   );

   always #5 clk = ~clk;

   // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got %h, expected %h", tag, obs, exp);
   endtask

   // Offer four partial products back to back, checking pp_idx/pp_ready before each accept.
   task automatic run_seq(input logic [8:0] a, input logic [8:0] b,
                          input logic [8:0] c, input logic [8:0] d);
      logic [8:0] v [4];
      v[0] = a; v[1] = b; v[2] = c; v[3] = d;
      for (int i = 0; i < 4; i++) begin
         check("pp_idx_step", {14'd0, pp_idx}, 16'(i));
         check("pp_ready_accum", {15'd0, pp_ready}, 16'd1);
         pp_valid = 1'b1;
         pp_data  = v[i];
         step();
      end
      pp_valid = 1'b0;
   endtask

   // Product must be visible right after the 4th accept; then take it.
   task automatic expect_and_take(input string tag, input logic [15:0] exp);
      check({tag, "_valid"}, {15'd0, prod_valid}, 16'd1);
      check({tag, "_data"}, prod_data, exp);
      check({tag, "_ready_low"}, {15'd0, pp_ready}, 16'd0);
      prod_ready = 1'b1;
      step();
      prod_ready = 1'b0;
      check({tag, "_valid_drop"}, {15'd0, prod_valid}, 16'd0);
      check({tag, "_idx0"}, {14'd0, pp_idx}, 16'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_prod_valid"}, {15'd0, prod_valid}, 16'd0);
      check({tag, "_pp_ready"}, {15'd0, pp_ready}, 16'd1);
      check({tag, "_pp_idx"}, {14'd0, pp_idx}, 16'd0);
      check({tag, "_prod_data"}, prod_data, 16'h0000);
`ifdef BOOTH_ACC_CNT_EN
      check({tag, "_prod_count"}, prod_count, 16'd0);
`endif
   endtask

   initial begin
      rst        = 1'b1;
      pp_valid   = 1'b0;
      pp_data    = '0;
      pp_clear   = 1'b0;
      prod_ready = 1'b0;
      step();
      step();
      check_reset_outputs("reset");
      rst = 1'b0;

      // 5 x 3 with prod_ready held high throughout: -5 + (5<<2) = 15
      prod_ready = 1'b1;
      run_seq(9'h1FB, 9'h005, 9'h000, 9'h000);
      check("5x3_valid", {15'd0, prod_valid}, 16'd1);
      check("5x3_data", prod_data, 16'h000F);
      check("5x3_idx_wrap", {14'd0, pp_idx}, 16'd0);
      step();
      prod_ready = 1'b0;
      check("5x3_taken", {15'd0, prod_valid}, 16'd0);

      // 127 x -128: -254 << 6 = -16256
      run_seq(9'h000, 9'h000, 9'h000, 9'h102);
      expect_and_take("127xm128", 16'hC080);

      // All -1 digits: -(1+4+16+64) = -85
      run_seq(9'h1FF, 9'h1FF, 9'h1FF, 9'h1FF);
      expect_and_take("neg85", 16'hFFAB);

      // 9'h100 is -256 at the top digit: -256 << 6 = -16384
      run_seq(9'h000, 9'h000, 9'h000, 9'h100);
      expect_and_take("m256_top", 16'hC000);

      // Max positive: 254 * 85 = 21590, then hold with prod_ready low while pp is offered
      run_seq(9'h0FE, 9'h0FE, 9'h0FE, 9'h0FE);
      pp_valid = 1'b1;
      pp_data  = 9'h0FE;
      for (int i = 0; i < 3; i++) begin
         step();
         check("hold_valid", {15'd0, prod_valid}, 16'd1);
         check("hold_data", prod_data, 16'h5456);
         check("hold_pp_ready", {15'd0, pp_ready}, 16'd0);
      end
      pp_valid   = 1'b0;
      prod_ready = 1'b1;
      step();
      prod_ready = 1'b0;
      check("hold_taken", {15'd0, prod_valid}, 16'd0);
      check("hold_idx0", {14'd0, pp_idx}, 16'd0);
      run_seq(9'h1FB, 9'h005, 9'h000, 9'h000);
      expect_and_take("after_hold", 16'h000F);

      // pp_clear after two accepts, together with a valid beat that must be dropped
      pp_valid = 1'b1;
      pp_data  = 9'h0FE;
      step();
      step();
      check("clr_pre_idx", {14'd0, pp_idx}, 16'd2);
      pp_clear = 1'b1;
      step();
      pp_clear = 1'b0;
      pp_valid = 1'b0;
      check("clr_idx", {14'd0, pp_idx}, 16'd0);
      check("clr_valid", {15'd0, prod_valid}, 16'd0);
      check("clr_ready", {15'd0, pp_ready}, 16'd1);
      run_seq(9'h1FB, 9'h005, 9'h000, 9'h000);
      expect_and_take("after_clr", 16'h000F);

      // rst while a product waits in DONE
      run_seq(9'h0FE, 9'h0FE, 9'h0FE, 9'h0FE);
      check("rst_done_pre", {15'd0, prod_valid}, 16'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check_reset_outputs("rst_done");

      // rst mid-accumulation, then a clean product shows no residue
      pp_valid = 1'b1;
      pp_data  = 9'h0FE;
      step();
      step();
      pp_valid = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      check_reset_outputs("rst_mid");
      run_seq(9'h1FB, 9'h005, 9'h000, 9'h000);
      expect_and_take("after_rst", 16'h000F);

`ifdef BOOTH_ACC_CNT_EN
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("cnt_reset", prod_count, 16'd0);
      for (int i = 0; i < 3; i++) begin
         run_seq(9'h1FB, 9'h005, 9'h000, 9'h000);
         expect_and_take("cnt_prod", 16'h000F);
      end
      run_seq(9'h1FB, 9'h005, 9'h000, 9'h000);
      pp_clear = 1'b1;
      step();
      pp_clear = 1'b0;
      check("cnt_clr_valid", {15'd0, prod_valid}, 16'd0);
      check("cnt_three", prod_count, 16'd3);
      force dut.cnt = 16'hFFFF;
      step();
      release dut.cnt;
      check("cnt_preload", prod_count, 16'hFFFF);
      run_seq(9'h1FB, 9'h005, 9'h000, 9'h000);
      expect_and_take("cnt_wrap_prod", 16'h000F);
      check("cnt_wrap", prod_count, 16'd0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
